// File: rtl/gpio_core.sv
// Purpose: register/decode core of the GPIO peripheral (two GPO registers, two GPI read ports).
// Latency: read path is combinational; a write is visible on gpo_x and rd right after its clock edge.
// Backpressure: none; the bus always accepts writes and reads complete in the same cycle.
module gpio_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       A,
  input  logic             we,
  input  logic [WIDTH-1:0] wd,
  input  logic [WIDTH-1:0] gpi_1,
  input  logic [WIDTH-1:0] gpi_2,
  output logic [WIDTH-1:0] rd,
  output logic [WIDTH-1:0] gpo_1,
  output logic [WIDTH-1:0] gpo_2,
  output logic             we1,
  output logic             we2,
  output logic [1:0]       rd_sel
);

  // Word-address decode: only the two GPO addresses accept writes, so we1/we2 are mutually exclusive.
  always_comb begin
    we1    = 1'b0;
    we2    = 1'b0;
    rd_sel = A;
    case (A)
      2'b10:   we1 = we;
      2'b11:   we2 = we;
      default: begin
        we1 = 1'b0;
        we2 = 1'b0;
      end
    endcase
  end

  // Read mux: inputs pass straight through; GPO addresses return the stored value, never wd.
  always_comb begin
    rd = '0;
    case (rd_sel)
      2'b00:   rd = gpi_1;
      2'b01:   rd = gpi_2;
      2'b10:   rd = gpo_1;
      2'b11:   rd = gpo_2;
      default: rd = '0;
    endcase
  end

  // GPO register 1: reset wins over a simultaneous write, otherwise load on enable or hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      gpo_1 <= '0;
    end else if (we1) begin
      gpo_1 <= wd;
    end
  end

  // GPO register 2: same capture behaviour as register 1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      gpo_2 <= '0;
    end else if (we2) begin
      gpo_2 <= wd;
    end
  end

endmodule

// File: tb/tb_gpio_core.sv
// Purpose: directed self-checking bench for gpio_core with a scoreboard of expected values.
// Latency: samples 1 time unit after each rising edge, or between edges for combinational paths.
// Backpressure: not applicable; the design has no flow control.
module tb_gpio_core;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic [1:0]       A;
  logic             we;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] gpi_1;
  logic [WIDTH-1:0] gpi_2;
  logic [WIDTH-1:0] rd;
  logic [WIDTH-1:0] gpo_1;
  logic [WIDTH-1:0] gpo_2;
  logic             we1;
  logic             we2;
  logic [1:0]       rd_sel;

  gpio_core #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .A      (A),
    .we     (we),
    .wd     (wd),
    .gpi_1  (gpi_1),
    .gpi_2  (gpi_2),
    .rd     (rd),
    .gpo_1  (gpo_1),
    .gpo_2  (gpo_2),
    .we1    (we1),
    .we2    (we2),
    .rd_sel (rd_sel)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Record what the design must show at the next observation point.
  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  // Pop the oldest expectation and compare it against an observed value.
  task automatic chk(input logic [31:0] obs);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst   = 1'b0;
    A     = 2'b10;
    we    = 1'b1;
    wd    = 32'hFFFF_FFFF;
    gpi_1 = 32'h0;
    gpi_2 = 32'h0;

    // Reset held for two edges while a write to gpo_1 is presented.
    push("rst_gpo_1", 32'h0);
    push("rst_gpo_2", 32'h0);
    push("rst_rd_a10", 32'h0);
    push("rst_we1_decode", 32'h1);
    step();
    step();
    chk(gpo_1);
    chk(gpo_2);
    chk(rd);
    chk({31'b0, we1});
    A = 2'b11;
    push("rst_rd_a11", 32'h0);
    #1;
    chk(rd);

    // Write gpo_1; before the edge rd shows the register, not wd.
    rst = 1'b1;
    A   = 2'b10;
    we  = 1'b1;
    wd  = 32'h1234_5678;
    push("w1_we1", 32'h1);
    push("w1_we2", 32'h0);
    push("w1_rd_sel", 32'h2);
    push("w1_rd_pre_edge", 32'h0);
    #1;
    chk({31'b0, we1});
    chk({31'b0, we2});
    chk({30'b0, rd_sel});
    chk(rd);
    push("w1_gpo_1", 32'h1234_5678);
    push("w1_gpo_2", 32'h0);
    push("w1_rd_post_edge", 32'h1234_5678);
    step();
    chk(gpo_1);
    chk(gpo_2);
    chk(rd);

    // Write gpo_2 then hold for three edges with we low and wd cleared.
    A  = 2'b11;
    wd = 32'hDEAD_BEEF;
    push("w2_we1", 32'h0);
    push("w2_we2", 32'h1);
    #1;
    chk({31'b0, we1});
    chk({31'b0, we2});
    push("w2_gpo_2", 32'hDEAD_BEEF);
    step();
    chk(gpo_2);
    we = 1'b0;
    wd = 32'h0;
    for (int i = 0; i < 3; i++) begin
      push("hold_gpo_2", 32'hDEAD_BEEF);
      push("hold_gpo_1", 32'h1234_5678);
      push("hold_rd", 32'hDEAD_BEEF);
      step();
      chk(gpo_2);
      chk(gpo_1);
      chk(rd);
    end

    // Read-only addresses return the inputs.
    gpi_1 = 32'hA5A5_A5A5;
    gpi_2 = 32'h5A5A_5A5A;
    A     = 2'b00;
    push("ro_rd_a00", 32'hA5A5_A5A5);
    #1;
    chk(rd);
    A = 2'b01;
    push("ro_rd_a01", 32'h5A5A_5A5A);
    #1;
    chk(rd);

    // Writes to read-only addresses are ignored.
    for (int a = 0; a < 2; a++) begin
      A  = a[1:0];
      we = 1'b1;
      wd = 32'hCAFE_F00D;
      push("ro_we1", 32'h0);
      push("ro_we2", 32'h0);
      #1;
      chk({31'b0, we1});
      chk({31'b0, we2});
      push("ro_gpo_1", 32'h1234_5678);
      push("ro_gpo_2", 32'hDEAD_BEEF);
      step();
      chk(gpo_1);
      chk(gpo_2);
    end

    // Input change shows on rd with no clock edge in between.
    we = 1'b0;
    A  = 2'b01;
    @(negedge clk);
    gpi_2 = 32'h0000_0001;
    push("comb_gpi_2", 32'h0000_0001);
    #2;
    chk(rd);

    // rd does not depend on we or wd.
    A  = 2'b10;
    we = 1'b0;
    wd = 32'h5555_AAAA;
    push("rd_no_we", 32'h1234_5678);
    #1;
    chk(rd);
    we = 1'b1;
    A  = 2'b11;
    push("rd_we_high", 32'hDEAD_BEEF);
    #1;
    chk(rd);
    we = 1'b0;

    // Reset collides with a write to gpo_1; reset wins.
    rst = 1'b0;
    A   = 2'b10;
    we  = 1'b1;
    wd  = 32'hFFFF_FFFF;
    push("coll_gpo_1", 32'h0);
    push("coll_gpo_2", 32'h0);
    step();
    chk(gpo_1);
    chk(gpo_2);

    // Release reset: first edge with rst high captures again.
    rst = 1'b1;
    wd  = 32'h0000_BEEF;
    push("resume_gpo_1", 32'h0000_BEEF);
    push("resume_rd", 32'h0000_BEEF);
    push("resume_gpo_2", 32'h0);
    step();
    chk(gpo_1);
    chk(rd);
    chk(gpo_2);

    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
